// File: rtl/cnt_ctrl.sv
// Button front end for the up/down counter: synchronises and debounces the
// direction and run buttons, toggles mode/enable on presses, prescales the tick.
module cnt_ctrl #(
    parameter int DEB_LEN  = 16,
    parameter int PRESCALE = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_dir,
    input  logic i_btn_run,
    output logic o_mode,
    output logic o_en,
    output logic o_tick
);

    localparam int DW = $clog2(DEB_LEN + 1);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_LEN - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    // bit 0 = direction button, bit 1 = run button
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stab;
    logic [1:0] stab_d;
    logic [1:0] press;
    logic [DW-1:0] dcnt [2];
    logic [PW-1:0] pcnt;

    assign raw   = {i_btn_run, i_btn_dir};
    assign press = stab & ~stab_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stab_d <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stab_d <= stab;
        end
    end

    // any cycle where sync matches stable restarts qualification
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stab <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stab[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_MAX) begin
                    stab[i] <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_mode <= 1'b0;
            o_en   <= 1'b0;
        end else begin
            o_mode <= o_mode ^ press[0];
            o_en   <= o_en ^ press[1];
        end
    end

    // tick is registered, so it lands one cycle after the counter hits the top
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pcnt   <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= o_en && (pcnt == PRE_MAX);
            if (!o_en || pcnt == PRE_MAX) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed bench for cnt_ctrl with DEB_LEN=4, PRESCALE=5.
module tb_cnt_ctrl;

    logic i_clk;
    logic i_rst_n;
    logic i_btn_dir;
    logic i_btn_run;
    logic o_mode;
    logic o_en;
    logic o_tick;

    int n_chk;
    int n_fail;
    int cyc;
    int tick_first;
    logic exp_mode;
    logic exp_en;
    logic exp_tick;

    cnt_ctrl #(
        .DEB_LEN (4),
        .PRESCALE(5)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_btn_dir(i_btn_dir),
        .i_btn_run(i_btn_run),
        .o_mode   (o_mode),
        .o_en     (o_en),
        .o_tick   (o_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    // advance n edges, checking all outputs #1 after each edge
    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
            cyc++;
            exp_tick = (tick_first >= 0) && (cyc >= tick_first)
                       && (((cyc - tick_first) % 5) == 0);
            chk("mode", o_mode, exp_mode);
            chk("en", o_en, exp_en);
            chk("tick", o_tick, exp_tick);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        cyc        = 0;
        tick_first = -1;
        exp_mode   = 1'b0;
        exp_en     = 1'b0;
        i_rst_n    = 1'b0;
        i_btn_dir  = 1'b0;
        i_btn_run  = 1'b0;

        // reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_mode", o_mode, 1'b0);
        chk("rst_en", o_en, 1'b0);
        chk("rst_tick", o_tick, 1'b0);
        i_rst_n = 1'b1;

        // run press: o_en at edge 7, ticks every 5 from edge 12
        i_btn_run = 1'b1;
        adv(6);
        exp_en     = 1'b1;
        tick_first = 12;
        adv(14);
        i_btn_run = 1'b0;
        adv(8);

        // direction toggle while running, release ignored
        i_btn_dir = 1'b1;
        adv(6);
        exp_mode = 1'b1;
        adv(9);
        i_btn_dir = 1'b0;
        adv(12);
        i_btn_dir = 1'b1;
        adv(6);
        exp_mode = 1'b0;
        adv(4);
        i_btn_dir = 1'b0;
        adv(8);

        // bounce 1,1,1,0 never qualifies
        for (int i = 0; i < 40; i++) begin
            i_btn_dir = (i % 4 != 3);
            adv(1);
        end
        i_btn_dir = 1'b1;
        adv(6);
        exp_mode = 1'b1;
        adv(10);
        i_btn_dir = 1'b0;
        adv(8);

        // pause: no ticks while paused
        i_btn_run = 1'b1;
        adv(6);
        exp_en     = 1'b0;
        tick_first = -1;
        adv(11);
        i_btn_run = 1'b0;
        adv(8);

        // resume: first tick 5 cycles after o_en rises
        i_btn_run = 1'b1;
        adv(6);
        exp_en     = 1'b1;
        tick_first = 174;
        adv(13);
        i_btn_run = 1'b0;
        adv(11);

        // pause landing on a tick cycle: tick still fires
        i_btn_run = 1'b1;
        adv(6);
        exp_en = 1'b0;
        adv(1);
        tick_first = -1;
        adv(8);
        i_btn_run = 1'b0;
        adv(8);

        // reset at debounce count 2, then full re-qualification
        i_btn_run = 1'b1;
        adv(4);
        i_rst_n  = 1'b0;
        exp_mode = 1'b0;
        exp_en   = 1'b0;
        adv(1);
        i_rst_n = 1'b1;
        adv(6);
        exp_en     = 1'b1;
        tick_first = 232;
        adv(7);
        i_btn_run = 1'b0;
        adv(8);

        // simultaneous presses toggle on the same edge
        i_btn_dir = 1'b1;
        i_btn_run = 1'b1;
        adv(6);
        exp_mode   = 1'b1;
        exp_en     = 1'b0;
        tick_first = -1;
        adv(6);
        i_btn_dir = 1'b0;
        i_btn_run = 1'b0;
        adv(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
